// File: rtl/fp_arb_pkg.sv
// Shared types and helpers for the floating-point unit arbiter.
// Holds the FSM state encoding and the rotating-priority pick function.
package fp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam int DW_DEF  = 32;
    localparam int MAX_REQ = 8;

    // Returns {found, index} of the first set bit scanning ptr, ptr+1, ... modulo n.
    // Scans from the farthest offset down so the nearest hit overwrites the rest.
    function automatic logic [3:0] rot_pick(input logic [MAX_REQ-1:0] req,
                                            input logic [2:0]         ptr,
                                            input int                 n);
        logic [3:0] res;
        int         j;
        logic [2:0] jj;
        res = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                j = int'(ptr) + k;
                if (j >= n) j = j - n;
                jj = 3'(j);
                if (req[jj]) res = {1'b1, jj};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fp_unit_arbiter_if.sv
// Requester-side bus of the FP unit arbiter: per-requester request/operands
// and the shared valid/ready response channel.
interface fp_unit_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 32
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_op_1;
    logic [NREQ*DW-1:0] req_op_2;
    logic [NREQ*DW-1:0] req_op_3;
    logic               rsp_valid;
    logic [IDW-1:0]     rsp_id;
    logic [DW-1:0]      rsp_data_1;
    logic [DW-1:0]      rsp_data_2;
    logic               rsp_ready;

    modport slave (
        input  req_valid, req_op_1, req_op_2, req_op_3, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data_1, rsp_data_2
    );

    modport master (
        output req_valid, req_op_1, req_op_2, req_op_3, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data_1, rsp_data_2
    );

endinterface

// File: rtl/fp_unit_arbiter_rr_pick.sv
// Combinational requester pick: rotating priority starting at ptr_i, or
// fixed lowest-index priority when FP_ARB_FIXED_PRIO_EN is defined.
module rr_pick
    import fp_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);
    logic [3:0] pick;
    logic [2:0] ptr_ext;

`ifdef FP_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;
    assign ptr_ext    = 3'd0;
`else
    assign ptr_ext    = 3'(ptr_i);
`endif

    assign pick  = rot_pick(8'(req_i), ptr_ext, NREQ);
    assign any_o = pick[3];
    assign idx_o = IDW'(pick[2:0]);
    assign gnt_o = any_o ? (NREQ'(1) << idx_o) : '0;

endmodule

// File: rtl/fp_unit_arbiter.sv
// Shares one fixed-latency FP unit between NREQ requesters, one operation in flight.
// Build option FP_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module fp_unit_arbiter
    import fp_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = DW_DEF,
    parameter int LAT  = 2,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fp_unit_arbiter_if.slave     bus,
    output logic [DW-1:0]        fpu_in_1,
    output logic [DW-1:0]        fpu_in_2,
    output logic [DW-1:0]        fpu_in_3,
    output logic                 fpu_start,
    input  logic [DW-1:0]        fpu_out_1,
    input  logic [DW-1:0]        fpu_out_2,
    output logic                 busy,
    output logic [CNTW-1:0]      ops_done
);
    localparam int IDW = $clog2(NREQ);

    arb_state_e      state_q, state_d;
    logic [IDW-1:0]  gnt_q, gnt_d;
    logic [DW-1:0]   op1_q, op1_d, op2_q, op2_d, op3_q, op3_d;
    logic [DW-1:0]   res1_q, res1_d, res2_q, res2_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [CNTW-1:0] ops_q, ops_d;
    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] pick_gnt;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;

`ifdef FP_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    assign ptr = rr_ptr_q;
`endif

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i (bus.req_valid),
        .ptr_i (ptr),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        op1_d         = op1_q;
        op2_d         = op2_q;
        op3_d         = op3_q;
        res1_d        = res1_q;
        res2_d        = res2_q;
        cnt_d         = cnt_q;
        ops_d         = ops_q;
`ifndef FP_ARB_FIXED_PRIO_EN
        rr_ptr_d      = rr_ptr_q;
`endif
        bus.req_ready = '0;
        fpu_start     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    bus.req_ready = pick_gnt;
                    gnt_d         = pick_idx;
                    op1_d         = bus.req_op_1[pick_idx*DW +: DW];
                    op2_d         = bus.req_op_2[pick_idx*DW +: DW];
                    op3_d         = bus.req_op_3[pick_idx*DW +: DW];
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                fpu_start = 1'b1;
                cnt_d     = 4'(LAT);
                // A zero-latency unit answers in the issue cycle itself.
                if (LAT == 0) begin
                    res1_d  = fpu_out_1;
                    res2_d  = fpu_out_2;
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    res1_d  = fpu_out_1;
                    res2_d  = fpu_out_2;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    ops_d    = ops_q + 1'b1;
`ifndef FP_ARB_FIXED_PRIO_EN
                    rr_ptr_d = (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
`endif
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            op3_q    <= '0;
            res1_q   <= '0;
            res2_q   <= '0;
            cnt_q    <= '0;
            ops_q    <= '0;
`ifndef FP_ARB_FIXED_PRIO_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            op3_q    <= op3_d;
            res1_q   <= res1_d;
            res2_q   <= res2_d;
            cnt_q    <= cnt_d;
            ops_q    <= ops_d;
`ifndef FP_ARB_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    assign fpu_in_1       = op1_q;
    assign fpu_in_2       = op2_q;
    assign fpu_in_3       = op3_q;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = gnt_q;
    assign bus.rsp_data_1 = res1_q;
    assign bus.rsp_data_2 = res2_q;
    assign busy           = (state_q != IDLE);
    assign ops_done       = ops_q;

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Bench for fp_unit_arbiter: a LAT=2/CNTW=4 instance with a scoreboard and a LAT=0 instance.
// Honours FP_ARB_FIXED_PRIO_EN for the expected grant order.
module tb_fp_unit_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int LAT  = 2;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] r1;
        logic [31:0] r2;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp_unit_arbiter_if #(.NREQ(NREQ), .DW(DW)) bi ();
    fp_unit_arbiter_if #(.NREQ(NREQ), .DW(DW)) bi0 ();

    logic [DW-1:0] fi_1, fi_2, fi_3, fo_1, fo_2;
    logic          fs, busy;
    logic [3:0]    ops_done;
    logic [DW-1:0] fi0_1, fi0_2, fi0_3, fo0_1, fo0_2;
    logic          fs0, busy0;
    logic [15:0]   ops_done0;

    fp_unit_arbiter #(.NREQ(NREQ), .DW(DW), .LAT(LAT), .CNTW(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bi),
        .fpu_in_1(fi_1), .fpu_in_2(fi_2), .fpu_in_3(fi_3), .fpu_start(fs),
        .fpu_out_1(fo_1), .fpu_out_2(fo_2), .busy(busy), .ops_done(ops_done)
    );

    fp_unit_arbiter #(.NREQ(NREQ), .DW(DW), .LAT(0), .CNTW(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bi0),
        .fpu_in_1(fi0_1), .fpu_in_2(fi0_2), .fpu_in_3(fi0_3), .fpu_start(fs0),
        .fpu_out_1(fo0_1), .fpu_out_2(fo0_2), .busy(busy0), .ops_done(ops_done0)
    );

    function automatic logic [31:0] f1(logic [31:0] a, logic [31:0] b, logic [31:0] c);
        return c + (b ^ 32'h4000_0000);
    endfunction
    function automatic logic [31:0] f2(logic [31:0] a, logic [31:0] b, logic [31:0] c);
        return a ^ 32'h8000_0000 ^ (b ^ 32'h4000_0000);
    endfunction

    // Unit model: results valid exactly LAT cycles after the start strobe, garbage otherwise.
    logic [31:0] p1 [LAT];
    logic [31:0] p2 [LAT];
    logic        pv [LAT];
    always @(posedge clk) begin
        pv[0] <= fs;
        p1[0] <= f1(fi_1, fi_2, fi_3);
        p2[0] <= f2(fi_1, fi_2, fi_3);
        for (int k = 1; k < LAT; k++) begin
            pv[k] <= pv[k-1];
            p1[k] <= p1[k-1];
            p2[k] <= p2[k-1];
        end
    end
    assign fo_1  = pv[LAT-1] ? p1[LAT-1] : 32'hDEAD_BEEF;
    assign fo_2  = pv[LAT-1] ? p2[LAT-1] : 32'hDEAD_BEEF;
    assign fo0_1 = fs0 ? f1(fi0_1, fi0_2, fi0_3) : 32'hDEAD_BEEF;
    assign fo0_2 = fs0 ? f2(fi0_1, fi0_2, fi0_3) : 32'hDEAD_BEEF;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int model_pick(logic [NREQ-1:0] req, int ptr);
        int j;
        for (int k = 0; k < NREQ; k++) begin
            j = (ptr + k) % NREQ;
            if (req[j]) return j;
        end
        return 0;
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / scoreboard for the main instance, sampled on the falling edge.
    exp_t        sb [$];
    logic [1:0]  ids [$];
    exp_t        e;
    int          m_ptr = 0, m_idx, acc_cyc = 0, hs_cyc = 0;
    bit          hs_pend = 0, rsp_first = 1, rv_pend = 0;
    logic [3:0]  exp_ops = 0;
    logic [31:0] l1, l2, l3, pd1, pd2;
    logic [1:0]  pid;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            m_ptr = 0; exp_ops = 0; hs_pend = 0; rsp_first = 1; rv_pend = 0;
        end else begin
            if (!busy && bi.req_valid != 0) begin
                m_idx = model_pick(bi.req_valid, m_ptr);
                check("grant", bi.req_ready, 64'(1) << m_idx);
                l1 = bi.req_op_1[m_idx*DW +: DW];
                l2 = bi.req_op_2[m_idx*DW +: DW];
                l3 = bi.req_op_3[m_idx*DW +: DW];
                e.id = 2'(m_idx); e.r1 = f1(l1, l2, l3); e.r2 = f2(l1, l2, l3);
                sb.push_back(e);
                acc_cyc = cyc;
                if (hs_pend) check("regrant_cycle", cyc, hs_cyc + 1);
                hs_pend = 0;
            end else if (bi.req_valid != 0) begin
                check("ready_while_busy", bi.req_ready, 0);
            end
            if (fs) check("start_latency", cyc, acc_cyc + 1);
            if (busy && !bi.rsp_valid) begin
                check("fpu_in_1", fi_1, l1);
                check("fpu_in_2", fi_2, l2);
                check("fpu_in_3", fi_3, l3);
            end
            if (rv_pend && !bi.rsp_valid) check("rsp_valid_dropped", 0, 1);
            if (bi.rsp_valid) begin
                if (rsp_first) begin
                    check("rsp_latency", cyc - acc_cyc, LAT + 2);
                    rsp_first = 0;
                    pd1 = bi.rsp_data_1; pd2 = bi.rsp_data_2; pid = bi.rsp_id;
                end else begin
                    check("hold_data_1", bi.rsp_data_1, pd1);
                    check("hold_data_2", bi.rsp_data_2, pd2);
                    check("hold_id", bi.rsp_id, pid);
                end
                if (bi.rsp_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_rsp", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_id", bi.rsp_id, e.id);
                        check("rsp_data_1", bi.rsp_data_1, e.r1);
                        check("rsp_data_2", bi.rsp_data_2, e.r2);
                        ids.push_back(bi.rsp_id);
`ifndef FP_ARB_FIXED_PRIO_EN
                        m_ptr = (int'(e.id) + 1) % NREQ;
`endif
                    end
                    check("ops_done", ops_done, exp_ops);
                    exp_ops = exp_ops + 4'd1;
                    hs_cyc = cyc; hs_pend = (bi.req_valid != 0); rsp_first = 1;
                end
            end
            rv_pend = bi.rsp_valid && !bi.rsp_ready;
        end
    end

    // Stimulus tasks start and end at posedge+1.
    task automatic wait_accept(input int budget);
        bit got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            #1;
            if (bi.req_ready != 0) got = 1;
            @(posedge clk); #1;
        end
        if (!got) check("accept_timeout", 0, 1);
    endtask

    task automatic run_ops(input int n, input int budget);
        int cnt = 0;
        for (int i = 0; i < budget && cnt < n; i++) begin
            #1;
            if (bi.rsp_valid && bi.rsp_ready) begin
                cnt++;
                if (cnt == n) bi.req_valid = '0;
            end
            @(posedge clk); #1;
        end
        if (cnt != n) check("response_timeout", cnt, n);
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            bi.req_op_1[i*DW +: DW] = $urandom;
            bi.req_op_2[i*DW +: DW] = $urandom;
            bi.req_op_3[i*DW +: DW] = $urandom;
        end
    endtask

    logic [31:0] a0, b0, c0;
    bit          found;

    initial begin
        rst_n = 1'b0;
        bi.req_valid = '0; bi.rsp_ready = 1'b1;
        bi0.req_valid = '0; bi0.rsp_ready = 1'b1;
        bi0.req_op_1 = '0; bi0.req_op_2 = '0; bi0.req_op_3 = '0;
        rand_ops();
        @(posedge clk); #1;
        check("rst_ready", bi.req_ready, 0);
        check("rst_busy", {busy, fs, bi.rsp_valid}, 0);
        check("rst_ops_done", ops_done, 0);
        check("rst_rsp", {bi.rsp_id, bi.rsp_data_1, bi.rsp_data_2}, 0);
        check("rst_fpu_in", {fi_1, fi_2}, 0);
        check("rst0_busy", {busy0, fs0, bi0.rsp_valid, bi0.req_ready}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All four requesters held for eight operations.
        ids.delete();
        bi.req_valid = 4'hF;
        run_ops(8, 80);
        check("order_count", ids.size(), 8);
        for (int k = 0; k < 8 && k < ids.size(); k++) begin
`ifdef FP_ARB_FIXED_PRIO_EN
            check($sformatf("order_%0d", k), ids[k], 0);
`else
            check($sformatf("order_%0d", k), ids[k], k % NREQ);
`endif
        end

        // Single request from requester 1 with the reference operands.
        bi.req_op_1[1*DW +: DW] = 32'h3F80_0000;
        bi.req_op_2[1*DW +: DW] = 32'h4000_0000;
        bi.req_op_3[1*DW +: DW] = 32'h4040_0000;
        bi.req_valid = 4'b0010;
        wait_accept(10);
        bi.req_valid = '0;
        run_ops(1, 20);
        check("ops_after_single", ops_done, 4'd9);

        // Backpressure with requester 3 waiting behind requester 2.
        rand_ops();
        bi.rsp_ready = 1'b0;
        bi.req_valid = 4'b0100;
        wait_accept(10);
        bi.req_valid = 4'b1000;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            #1;
            if (bi.rsp_valid) found = 1;
            @(posedge clk); #1;
        end
        if (!found) check("bp_rsp_timeout", 0, 1);
        repeat (9) @(posedge clk);
        #1;
        bi.rsp_ready = 1'b1;
        run_ops(2, 30);

        // Move the pointer off zero, then reset during WAIT.
        bi.req_valid = 4'b0010;
        wait_accept(10);
        bi.req_valid = '0;
        run_ops(1, 20);
        bi.req_valid = 4'b1000;
        wait_accept(10);
        bi.req_valid = '0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            #1;
            if (fs) found = 1;
            @(posedge clk); #1;
        end
        if (!found) check("start_timeout", 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {busy, fs, bi.rsp_valid, bi.req_ready}, 0);
        check("arst_ops_done", ops_done, 0);
        check("arst_rsp", {bi.rsp_id, bi.rsp_data_1, bi.rsp_data_2}, 0);
        check("arst_fpu_in", {fi_1, fi_2, fi_3}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("post_rst_rsp_valid", bi.rsp_valid, 0);
        end

        // Seventeen operations wrap the 4-bit counter to 1.
        ids.delete();
        rand_ops();
        bi.req_valid = 4'hF;
        run_ops(17, 200);
        check("post_rst_first_id", (ids.size() > 0) ? ids[0] : 2'd3, 0);
        check("ops_wrap", ops_done, 4'd1);

        // Zero-latency instance.
        a0 = $urandom; b0 = $urandom; c0 = $urandom;
        bi0.req_op_1[2*DW +: DW] = a0;
        bi0.req_op_2[2*DW +: DW] = b0;
        bi0.req_op_3[2*DW +: DW] = c0;
        bi0.req_valid = 4'b0100;
        #1;
        check("l0_ready", bi0.req_ready, 4'b0100);
        @(posedge clk); #1;
        bi0.req_valid = '0;
        #1;
        check("l0_start", fs0, 1);
        check("l0_fpu_in", {fi0_1, fi0_2, fi0_3}, {a0, b0, c0});
        @(posedge clk); #2;
        check("l0_rsp_valid", bi0.rsp_valid, 1);
        check("l0_rsp_id", bi0.rsp_id, 2);
        check("l0_rsp_data", {bi0.rsp_data_1, bi0.rsp_data_2}, {f1(a0, b0, c0), f2(a0, b0, c0)});
        @(posedge clk); #2;
        check("l0_ops_done", ops_done0, 1);
        check("l0_rsp_clear", bi0.rsp_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fp_unit_arbiter.md
Name: fp_unit_arbiter

Overview:
- Shares one floating-point compute unit (three 32-bit operands in, two 32-bit results out, fixed latency LAT) between NREQ requesters.
- Arbitrates round-robin and latches the winner's operands.
- Issues one operation, waits out the unit latency, captures both results and returns them to the winning requester over a valid/ready response.
- Sits between requester front-ends and the floating_test-class datapath; exactly one operation is in flight at a time.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 32, operand/result width.
- LAT, 2, cycles from fpu_start to fpu_out valid (0..15; 0 = combinational unit).
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- req_op_1/req_op_2/req_op_3  in  NREQ*DW each  operands; requester i occupies bits [i*DW +: DW].
- fpu_in_1/fpu_in_2/fpu_in_3  out  DW  operands to the unit.
- fpu_start  out  1  one-cycle issue strobe.
- fpu_out_1/fpu_out_2  in  DW  unit results.
- rsp_valid  out  1  response valid.
- rsp_id  out  $clog2(NREQ)  index of the requester owning the response.
- rsp_data_1/rsp_data_2  out  DW  captured results.
- rsp_ready  in  1  response accept.
- busy  out  1  high whenever state != IDLE.
- ops_done  out  CNTW  completed-response count, wraps.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0.
  - All outputs 0: req_ready, fpu_start, fpu_in_*, rsp_valid, rsp_id, rsp_data_*, busy, ops_done.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, grant the first asserted index scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready[grant] is combinationally high this cycle only, so the handshake completes in the same cycle.
  - Latch the operands and grant index; next state ISSUE.
  - No req_valid: remain in IDLE, req_ready=0.
- ISSUE (1 cycle):
  - fpu_start=1; fpu_in_* driven from latches and held stable until exit from WAIT.
  - Load wait counter with LAT.
  - LAT=0: capture fpu_out_* at this edge, go to RESP.
  - Otherwise go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When the counter reaches 1, capture fpu_out_* at that edge (exactly LAT cycles after the fpu_start cycle) and go to RESP.
- RESP:
  - rsp_valid=1; rsp_id and rsp_data_* stable until rsp_ready.
  - On rsp_valid & rsp_ready: ops_done += 1 (wraps at 2^CNTW), rr_ptr = (grant+1) mod NREQ, go to IDLE.
  - rsp_valid stays high indefinitely under backpressure.
- Latency:
  - Accept to rsp_valid = LAT+2 cycles (LAT>=1) or 2 cycles (LAT=0).
  - Minimum issue interval = LAT+3 cycles.
- req_ready is always 0 outside IDLE; requests arriving or changing then are ignored, and requesters must hold req_valid.
- Simultaneous requests: exactly one grant; losers wait. Every continuously requesting index is served within NREQ operations.
- rsp_ready while not in RESP is ignored.
- Reset mid-operation: in-flight result discarded, no response emitted, counter cleared.
- NREQ wrap: rr_ptr=NREQ-1 after grant wraps to 0.

Optional Feature:
- Macro FP_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr removed; a continuously asserting index 0 may starve others.
- Undefined (default): round-robin as above.
- All timing and handshake behaviour is identical in both builds.

Decomposition:
- Shared package fp_arb_pkg holds:
  - state enum (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3);
  - DW default;
  - function for the rotating priority pick.
- Sub-module rr_pick (inputs req vector and ptr, output one-hot grant and index); the only natural split. It is combinational, and its ptr logic is bypassed under FP_ARB_FIXED_PRIO_EN.
- FSM, latches and counters stay in fp_unit_arbiter.

Test Plan:
- Single request, LAT=2: req 1 operands 0x3F800000/0x40000000/0x40400000, model returns 0x40400000/0xBF800000.
  - Expect req_ready[1] same cycle.
  - Expect fpu_start one cycle later.
  - Expect rsp_valid 4 cycles after accept with rsp_id=1 and both results exact; ops_done=1.
- All four req_valid held high for 8 operations: expect rsp_id order 0,1,2,3,0,1,2,3. With FP_ARB_FIXED_PRIO_EN, expect all 0.
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP.
  - rsp_valid and rsp_data stable throughout; req_ready=0 throughout.
  - The next grant occurs the cycle after rsp_ready=1.
- LAT=0 build: response 2 cycles after accept; fpu_in_* match the latched operands during ISSUE.
- Reset: pulse rst_n low during WAIT.
  - All outputs 0 immediately (asynchronous).
  - No rsp_valid afterwards; the next request is served with rr_ptr=0.
- Counter wrap, CNTW=4: 17 operations -> ops_done=1.
